xbar_pea_banks_pipe: RTL and testbench

- Pipelined store-direction crossbar: routes PEA output words toward the memory banks of one stream.
- Mirror of the banks->PEA load crossbar: each bank lane selects one of N_PE PE outputs through cascaded N_PE_PER_BB-to-1 stages, with one register per stage.
- Sits between the PEA output registers and the bank write ports; per-bank selectors come from the store-stream config registers.

---
 rtl/xbar_pkg.sv | 31 +++
 rtl/xbar_bb_mux.sv | 57 +++++
 rtl/xbar_pea_banks_pipe.sv | 129 ++++++++++++
 tb/tb_xbar_pea_banks_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// ---------------------------------------------------------------------------
// xbar_pkg
// Shared constants and types for the PEA -> banks store crossbar.
//   N_PE / N_BANKS / DATA_W     : stream geometry
//   N_PE_PER_BB                 : basic-block mux radix
//   LOG_N_PE_PER_BB             : selector bits consumed per stage
//   N_PIPE_STAGE_PEA_BANKS      : pipeline depth (= latency in cycles)
//   N_BB_PEA_BANKS_STG_0/1      : basic blocks per lane in each stage
//   xbar_sel_t                  : per-lane source PE index
// ---------------------------------------------------------------------------
package xbar_pkg;

  localparam int N_PE                   = 16;
  localparam int N_BANKS                = 16;
  localparam int DATA_W                 = 32;
  localparam int N_PE_PER_BB            = 4;
  localparam int LOG_N_PE_PER_BB        = $clog2(N_PE_PER_BB);
  localparam int SEL_W                  = $clog2(N_PE);
  localparam int N_PIPE_STAGE_PEA_BANKS = SEL_W / LOG_N_PE_PER_BB;
  localparam int N_BB_PEA_BANKS_STG_0   = N_PE / N_PE_PER_BB;
  localparam int N_BB_PEA_BANKS_STG_1   = N_BB_PEA_BANKS_STG_0 / N_PE_PER_BB;

  typedef logic [SEL_W-1:0]           xbar_sel_t;
  typedef logic [LOG_N_PE_PER_BB-1:0] xbar_digit_t;

  // Extracts selector digit k (stage k's mux select) from a lane selector.
  function automatic xbar_digit_t sel_digit(input xbar_sel_t sel, input int unsigned k);
    return sel[k*LOG_N_PE_PER_BB +: LOG_N_PE_PER_BB];
  endfunction

endpackage

// File: rtl/xbar_bb_mux.sv
// ---------------------------------------------------------------------------
// xbar_bb_mux
// RADIX-to-1 basic-block mux for data plus valid, followed by one register.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   flush_i       : synchronous clear of the output valid (data untouched)
//   adv_i         : pipeline advance; register holds when low
//   sel_i         : which of the RADIX inputs to forward
//   in_data_i     : RADIX packed words, entry j at [j*DATA_W +: DATA_W]
//   in_valid_i    : RADIX valids
//   out_data_o    : registered selected word
//   out_valid_o   : registered selected valid
// ---------------------------------------------------------------------------
module xbar_bb_mux #(
  parameter int RADIX  = 4,
  parameter int DATA_W = 32,
  parameter int SEL_W  = $clog2(RADIX)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    adv_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [RADIX*DATA_W-1:0] in_data_i,
  input  logic [RADIX-1:0]        in_valid_i,
  output logic [DATA_W-1:0]       out_data_o,
  output logic                    out_valid_o
);

  logic [DATA_W-1:0] mux_data;
  logic              mux_valid;

  // Plain combinational select of one entry out of the basic block.
  always_comb begin
    mux_data  = in_data_i[sel_i*DATA_W +: DATA_W];
    mux_valid = in_valid_i[sel_i];
  end

  // Data loads on every advance even when the selected valid is low, so no
  // masking logic sits on the wide data path. Flush only touches the valid
  // and wins over advance, which also lets it act while the pipe is stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
    end else begin
      if (adv_i) begin
        out_data_o <= mux_data;
      end
      if (flush_i) begin
        out_valid_o <= 1'b0;
      end else if (adv_i) begin
        out_valid_o <= mux_valid;
      end
    end
  end

endmodule

// File: rtl/xbar_pea_banks_pipe.sv
// ---------------------------------------------------------------------------
// xbar_pea_banks_pipe
// Pipelined store-direction crossbar: each bank lane picks one of N_PE PE
// output words through a two-level tree of N_PE_PER_BB-to-1 muxes, with one
// register per level (latency = N_PIPE_STAGE_PEA_BANKS cycles).
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   flush_i       : synchronous clear of every pipeline valid
//   cfg_load_i    : capture cfg_sel_i / cfg_en_i at the next edge
//   cfg_sel_i     : per-lane source PE index, lane b at [b*SEL_W +: SEL_W]
//   cfg_en_i      : per-lane enable
//   pe_data_i     : PE output words, PE i at [i*DATA_W +: DATA_W]
//   pe_valid_i    : per-PE valid
//   pe_ready_o    : global accept, high whenever the pipeline advances
//   bank_data_o   : routed words, lane b at [b*DATA_W +: DATA_W]
//   bank_valid_o  : per-lane valid
//   bank_ready_i  : per-bank write accept
// ---------------------------------------------------------------------------
import xbar_pkg::*;

module xbar_pea_banks_pipe (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      cfg_load_i,
  input  logic [N_BANKS*SEL_W-1:0]  cfg_sel_i,
  input  logic [N_BANKS-1:0]        cfg_en_i,
  input  logic [N_PE*DATA_W-1:0]    pe_data_i,
  input  logic [N_PE-1:0]           pe_valid_i,
  output logic                      pe_ready_o,
  output logic [N_BANKS*DATA_W-1:0] bank_data_o,
  output logic [N_BANKS-1:0]        bank_valid_o,
  input  logic [N_BANKS-1:0]        bank_ready_i
);

  localparam int R     = N_PE_PER_BB;
  localparam int LOG_R = LOG_N_PE_PER_BB;

  xbar_sel_t           sel_q [N_BANKS];
  logic [N_BANKS-1:0]  en_q;
  xbar_digit_t         hi_q  [N_BANKS];
  logic                stall;
  logic                adv;

  // A single blocked bank holding a valid word freezes the whole crossbar,
  // keeping all lanes in lockstep. Disabled or idle lanes never present a
  // valid, so their ready inputs cannot cause a stall.
  always_comb begin
    stall      = |(bank_valid_o & ~bank_ready_i);
    adv        = ~stall;
    pe_ready_o = adv;
  end

  // Configuration registers. They are independent of stall and flush, so a
  // load issued while the pipe is frozen still takes effect immediately and
  // simply applies to the next word that enters stage 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < N_BANKS; b++) begin
        sel_q[b] <= '0;
      end
      en_q <= '0;
    end else if (cfg_load_i) begin
      for (int b = 0; b < N_BANKS; b++) begin
        sel_q[b] <= cfg_sel_i[b*SEL_W +: SEL_W];
      end
      en_q <= cfg_en_i;
    end
  end

  // The stage-1 selector digit travels with the data through stage 0, so a
  // reconfiguration never re-routes a word already in flight. With the tree
  // two levels deep, a single carried digit per lane is all that is needed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < N_BANKS; b++) begin
        hi_q[b] <= '0;
      end
    end else if (adv) begin
      for (int b = 0; b < N_BANKS; b++) begin
        hi_q[b] <= sel_digit(sel_q[b], 1);
      end
    end
  end

  // Per-lane mux tree: stage 0 has N_BB_PEA_BANKS_STG_0 blocks, each choosing
  // within one group of R PEs by the low digit; stage 1 picks the group.
  for (genvar b = 0; b < N_BANKS; b++) begin : g_lane
    logic [N_BB_PEA_BANKS_STG_0*DATA_W-1:0] s0_data;
    logic [N_BB_PEA_BANKS_STG_0-1:0]        s0_valid;
    logic [R-1:0]                           lane_en;

    assign lane_en = {R{en_q[b]}};

    for (genvar g = 0; g < N_BB_PEA_BANKS_STG_0; g++) begin : g_stg0
      xbar_bb_mux #(
        .RADIX  (R),
        .DATA_W (DATA_W),
        .SEL_W  (LOG_R)
      ) u_bb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .adv_i       (adv),
        .sel_i       (sel_digit(sel_q[b], 0)),
        .in_data_i   (pe_data_i[g*R*DATA_W +: R*DATA_W]),
        .in_valid_i  (pe_valid_i[g*R +: R] & lane_en),
        .out_data_o  (s0_data[g*DATA_W +: DATA_W]),
        .out_valid_o (s0_valid[g])
      );
    end

    xbar_bb_mux #(
      .RADIX  (N_BB_PEA_BANKS_STG_0),
      .DATA_W (DATA_W),
      .SEL_W  (LOG_R)
    ) u_stg1 (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .adv_i       (adv),
      .sel_i       (hi_q[b]),
      .in_data_i   (s0_data),
      .in_valid_i  (s0_valid),
      .out_data_o  (bank_data_o[b*DATA_W +: DATA_W]),
      .out_valid_o (bank_valid_o[b])
    );
  end

endmodule

// File: tb/tb_xbar_pea_banks_pipe.sv
// ---------------------------------------------------------------------------
// tb_xbar_pea_banks_pipe
// Directed self-checking bench for xbar_pea_banks_pipe. Inputs change and
// outputs are sampled 2 time units after each rising clock edge.
// ---------------------------------------------------------------------------
import xbar_pkg::*;

module tb_xbar_pea_banks_pipe;

  typedef logic [N_BANKS*DATA_W-1:0] bus_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic                      cfg_load;
  logic [N_BANKS*SEL_W-1:0]  cfg_sel;
  logic [N_BANKS-1:0]        cfg_en;
  logic [N_PE*DATA_W-1:0]    pe_data;
  logic [N_PE-1:0]           pe_valid;
  logic                      pe_ready;
  logic [N_BANKS*DATA_W-1:0] bank_data;
  logic [N_BANKS-1:0]        bank_valid;
  logic [N_BANKS-1:0]        bank_ready;

  int n_checks = 0;
  int n_fail   = 0;

  xbar_pea_banks_pipe dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .cfg_load_i   (cfg_load),
    .cfg_sel_i    (cfg_sel),
    .cfg_en_i     (cfg_en),
    .pe_data_i    (pe_data),
    .pe_valid_i   (pe_valid),
    .pe_ready_o   (pe_ready),
    .bank_data_o  (bank_data),
    .bank_valid_o (bank_valid),
    .bank_ready_i (bank_ready)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Word k as produced by PE i.
  function automatic logic [DATA_W-1:0] word_val(input int k, input int i);
    return 32'hA000_0000 + 32'(k) * 32'h100 + 32'(i);
  endfunction

  // All PE outputs for word k.
  function automatic logic [N_PE*DATA_W-1:0] word_vec(input int k);
    logic [N_PE*DATA_W-1:0] v;
    for (int i = 0; i < N_PE; i++) v[i*DATA_W +: DATA_W] = word_val(k, i);
    return v;
  endfunction

  // Lane b selects PE b.
  function automatic logic [N_BANKS*SEL_W-1:0] sel_identity();
    logic [N_BANKS*SEL_W-1:0] v;
    for (int b = 0; b < N_BANKS; b++) v[b*SEL_W +: SEL_W] = SEL_W'(b);
    return v;
  endfunction

  // Every lane selects PE s.
  function automatic logic [N_BANKS*SEL_W-1:0] sel_all(input int s);
    logic [N_BANKS*SEL_W-1:0] v;
    for (int b = 0; b < N_BANKS; b++) v[b*SEL_W +: SEL_W] = SEL_W'(s);
    return v;
  endfunction

  // All-ones over the data field of every lane set in m.
  function automatic bus_t lanes_mask(input logic [N_BANKS-1:0] m);
    bus_t v;
    for (int b = 0; b < N_BANKS; b++) v[b*DATA_W +: DATA_W] = {DATA_W{m[b]}};
    return v;
  endfunction

  task automatic stepClock();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [N_PE*DATA_W-1:0] data,
                               input logic [N_PE-1:0] valid,
                               input logic [N_BANKS-1:0] ready);
    pe_data    = data;
    pe_valid   = valid;
    bank_ready = ready;
  endtask

  task automatic loadConfig(input logic [N_BANKS*SEL_W-1:0] sel,
                            input logic [N_BANKS-1:0] en);
    cfg_sel  = sel;
    cfg_en   = en;
    cfg_load = 1'b1;
    stepClock();
    cfg_load = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input bus_t observed, input bus_t expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N_PE*DATA_W-1:0]    bvec;
    logic [N_BANKS*SEL_W-1:0]  sel;

    rst = 1'b1; flush = 1'b0; cfg_load = 1'b0;
    cfg_sel = '0; cfg_en = '0; pe_data = '0; pe_valid = '0; bank_ready = '1;

    // Reset state
    stepClock();
    stepClock();
    checkOutput("reset_valid", bus_t'(bank_valid), bus_t'(0));
    checkOutput("reset_data", bank_data, bus_t'(0));
    checkOutput("reset_ready", bus_t'(pe_ready), bus_t'(1));
    rst = 1'b0;

    // Identity routing, streaming one word per cycle
    $display("[TB] identity streaming");
    loadConfig(sel_identity(), 16'hFFFF);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(word_vec(k), (k < 4) ? 16'hFFFF : 16'h0000, 16'hFFFF);
      stepClock();
      if (k == 0) begin
        checkOutput("ident_latency_valid", bus_t'(bank_valid), bus_t'(0));
      end else if (k <= 4) begin
        checkOutput($sformatf("ident_valid_w%0d", k-1), bus_t'(bank_valid), bus_t'(16'hFFFF));
        checkOutput($sformatf("ident_data_w%0d", k-1), bank_data, word_vec(k-1));
      end else begin
        checkOutput("ident_drain_valid", bus_t'(bank_valid), bus_t'(0));
      end
    end

    // Broadcast of PE 5 to every lane
    $display("[TB] broadcast");
    applyStimulus(word_vec(0), 16'h0000, 16'hFFFF);
    loadConfig(sel_all(5), 16'hFFFF);
    bvec = word_vec(0);
    bvec[5*DATA_W +: DATA_W] = 32'hDEADBEEF;
    applyStimulus(bvec, 16'hFFFF, 16'hFFFF);
    stepClock();
    applyStimulus(bvec, 16'h0000, 16'hFFFF);
    stepClock();
    checkOutput("bcast_valid", bus_t'(bank_valid), bus_t'(16'hFFFF));
    checkOutput("bcast_data", bank_data, {N_BANKS{32'hDEADBEEF}});
    stepClock();
    checkOutput("bcast_drain_valid", bus_t'(bank_valid), bus_t'(0));

    // Stall on bank 3 for four cycles
    $display("[TB] stall");
    loadConfig(sel_identity(), 16'hFFFF);
    applyStimulus(word_vec(10), 16'hFFFF, 16'hFFFF);
    stepClock();
    applyStimulus(word_vec(11), 16'hFFFF, 16'hFFFF);
    stepClock();
    checkOutput("stall_pre_data", bank_data, word_vec(10));
    applyStimulus(word_vec(12), 16'hFFFF, 16'hFFF7);
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput($sformatf("stall_ready_c%0d", c), bus_t'(pe_ready), bus_t'(0));
      stepClock();
      checkOutput($sformatf("stall_frozen_data_c%0d", c), bank_data, word_vec(10));
      checkOutput($sformatf("stall_frozen_valid_c%0d", c), bus_t'(bank_valid), bus_t'(16'hFFFF));
    end
    applyStimulus(word_vec(12), 16'hFFFF, 16'hFFFF);
    #1;
    checkOutput("stall_release_ready", bus_t'(pe_ready), bus_t'(1));
    stepClock();
    checkOutput("stall_resume_w11", bank_data, word_vec(11));
    applyStimulus(word_vec(13), 16'h0000, 16'hFFFF);
    stepClock();
    checkOutput("stall_resume_w12", bank_data, word_vec(12));
    checkOutput("stall_resume_w12_valid", bus_t'(bank_valid), bus_t'(16'hFFFF));
    stepClock();
    checkOutput("stall_no_dup_valid", bus_t'(bank_valid), bus_t'(0));

    // Reconfiguration while a word is in flight
    $display("[TB] mid-flight reconfig");
    loadConfig(sel_all(2), 16'hFFFF);
    applyStimulus(word_vec(5), 16'hFFFF, 16'hFFFF);
    cfg_sel  = sel_all(9);
    cfg_load = 1'b1;
    stepClock();
    cfg_load = 1'b0;
    applyStimulus(word_vec(6), 16'hFFFF, 16'hFFFF);
    stepClock();
    checkOutput("reconf_old_route", bank_data, {N_BANKS{word_val(5, 2)}});
    applyStimulus(word_vec(6), 16'h0000, 16'hFFFF);
    stepClock();
    checkOutput("reconf_new_route", bank_data, {N_BANKS{word_val(6, 9)}});

    // Disabled lane 7, lane 0 pointing at invalid PE 4, bank 7 not ready
    $display("[TB] disabled lane and invalid source");
    sel = sel_identity();
    sel[0 +: SEL_W] = SEL_W'(4);
    loadConfig(sel, 16'hFF7F);
    applyStimulus(word_vec(7), 16'hFFEF, 16'hFF7F);
    stepClock();
    applyStimulus(word_vec(7), 16'h0000, 16'hFF7F);
    stepClock();
    checkOutput("dis_valid", bus_t'(bank_valid), bus_t'(16'hFF6E));
    checkOutput("dis_ready_ignored", bus_t'(pe_ready), bus_t'(1));
    checkOutput("dis_data", bank_data & lanes_mask(16'hFF6E), word_vec(7) & lanes_mask(16'hFF6E));
    applyStimulus(word_vec(7), 16'h0000, 16'hFFFF);
    stepClock();

    // Flush with two words in flight while stalled
    $display("[TB] flush");
    loadConfig(sel_identity(), 16'hFFFF);
    applyStimulus(word_vec(20), 16'hFFFF, 16'hFFFF);
    stepClock();
    applyStimulus(word_vec(21), 16'hFFFF, 16'hFFFF);
    stepClock();
    applyStimulus(word_vec(22), 16'hFFFF, 16'hFFF7);
    stepClock();
    checkOutput("flush_pre_ready", bus_t'(pe_ready), bus_t'(0));
    checkOutput("flush_pre_valid", bus_t'(bank_valid), bus_t'(16'hFFFF));
    flush = 1'b1;
    stepClock();
    flush = 1'b0;
    checkOutput("flush_valid", bus_t'(bank_valid), bus_t'(0));
    checkOutput("flush_ready", bus_t'(pe_ready), bus_t'(1));
    applyStimulus(word_vec(22), 16'h0000, 16'hFFFF);
    stepClock();
    checkOutput("flush_stage0_cleared", bus_t'(bank_valid), bus_t'(0));

    // Asynchronous reset mid-stream
    $display("[TB] async reset");
    applyStimulus(word_vec(30), 16'hFFFF, 16'hFFFF);
    stepClock();
    stepClock();
    checkOutput("rst_pre_data", bank_data, word_vec(30));
    rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", bus_t'(bank_valid), bus_t'(0));
    checkOutput("rst_async_data", bank_data, bus_t'(0));
    checkOutput("rst_async_ready", bus_t'(pe_ready), bus_t'(1));
    stepClock();
    rst = 1'b0;
    applyStimulus(word_vec(31), 16'hFFFF, 16'hFFFF);
    stepClock();
    stepClock();
    checkOutput("rst_lanes_disabled", bus_t'(bank_valid), bus_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
